// File: rtl/scan_scheduler.sv
// Two-scanner handoff sequencer: wakes the idle scanner ahead of time, grants the shared downlink, counts outcomes.
// All outputs registered (1-cycle latency from inputs); no backpressure, each command is a single-cycle pulse.
module scan_scheduler #(
    parameter int unsigned WAKE_LVL  = 80,
    parameter int unsigned START_LVL = 90,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mission_en,
    input  logic       link_ok,
    input  logic [2:0] state1,
    input  logic [2:0] state2,
    input  logic [7:0] mem_used1,
    input  logic [7:0] mem_used2,
    output logic       goto_stby1,
    output logic       goto_stby2,
    output logic       start_scan1,
    output logic       start_scan2,
    output logic       xfer1,
    output logic       xfer2,
    output logic       active,
    output logic [7:0] xfer_cnt,
    output logic [7:0] drop_cnt,
    output logic       fault
);

    localparam logic [2:0] SC_LOW_PWR  = 3'b000;
    localparam logic [2:0] SC_STBY     = 3'b001;
    localparam logic [2:0] SC_IDLE     = 3'b011;
    localparam logic [2:0] SC_XFERRING = 3'b101;

    typedef enum logic [2:0] {
        S_OFF, S_RUN, S_WAIT_STBY, S_ARMED, S_FILL, S_XFER, S_DRAIN
    } fsm_t;

    fsm_t       state, nxt_state;
    logic [7:0] timer, nxt_timer;
    logic       nxt_fault, nxt_active, nxt_grant;
    logic       stby_cmd, start_cmd, inc_xfer, inc_drop;

    logic [7:0] mem_a;
    logic [2:0] state_a, state_b;

    assign mem_a   = active ? mem_used2 : mem_used1;
    assign state_a = active ? state2 : state1;
    assign state_b = active ? state1 : state2;

    always_comb begin
        nxt_state  = state;
        nxt_timer  = timer;
        nxt_fault  = fault;
        nxt_active = active;
        nxt_grant  = 1'b0;
        stby_cmd   = 1'b0;
        start_cmd  = 1'b0;
        inc_xfer   = 1'b0;
        inc_drop   = 1'b0;
        case (state)
            S_OFF: begin
                if (mission_en) nxt_state = S_RUN;
            end
            S_RUN: begin
                if (!mission_en) begin
                    nxt_state = S_OFF;
                end else if (mem_a >= 8'(WAKE_LVL)) begin
                    stby_cmd  = 1'b1;
                    nxt_timer = 8'd0;
                    nxt_state = S_WAIT_STBY;
                end
            end
            S_WAIT_STBY: begin
                if (state_b == SC_STBY) begin
                    nxt_state = S_ARMED;
                end else if (timer == 8'(TIMEOUT)) begin
                    nxt_fault = 1'b1;
                    stby_cmd  = 1'b1;
                    nxt_timer = 8'd0;
                end else begin
                    nxt_timer = timer + 8'd1;
                end
            end
            S_ARMED: begin
                if (mem_a >= 8'(START_LVL)) begin
                    start_cmd = 1'b1;
                    nxt_state = S_FILL;
                end
            end
            S_FILL: begin
                // Entering XFER latches the grant high whatever link_ok says this cycle.
                if (state_a == SC_XFERRING) begin
                    nxt_state = S_XFER;
                    nxt_grant = 1'b1;
                end else if (state_a == SC_IDLE) begin
                    nxt_state = S_DRAIN;
                end else begin
                    nxt_grant = link_ok;
                end
            end
            S_XFER: begin
                if (state_a == SC_LOW_PWR) begin
                    inc_xfer   = 1'b1;
                    nxt_active = ~active;
                    nxt_state  = S_RUN;
                end else begin
                    nxt_grant = 1'b1;
                end
            end
            S_DRAIN: begin
                if (state_a == SC_LOW_PWR) begin
                    inc_drop   = 1'b1;
                    nxt_active = ~active;
                    nxt_state  = S_RUN;
                end
            end
            default: nxt_state = S_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_OFF;
            timer       <= 8'd0;
            fault       <= 1'b0;
            active      <= 1'b0;
            goto_stby1  <= 1'b0;
            goto_stby2  <= 1'b0;
            start_scan1 <= 1'b0;
            start_scan2 <= 1'b0;
            xfer1       <= 1'b0;
            xfer2       <= 1'b0;
            xfer_cnt    <= 8'd0;
            drop_cnt    <= 8'd0;
        end else begin
            state       <= nxt_state;
            timer       <= nxt_timer;
            fault       <= nxt_fault;
            active      <= nxt_active;
            // Commands target B, the scanner not currently active.
            goto_stby1  <= stby_cmd & active;
            goto_stby2  <= stby_cmd & ~active;
            start_scan1 <= start_cmd & active;
            start_scan2 <= start_cmd & ~active;
            xfer1       <= nxt_grant & ~nxt_active;
            xfer2       <= nxt_grant & nxt_active;
            if (inc_xfer && xfer_cnt != 8'hFF) xfer_cnt <= xfer_cnt + 8'd1;
            if (inc_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_scan_scheduler.sv
// Directed scenario bench for scan_scheduler with an expected-value queue per cycle.
module tb_scan_scheduler;

    localparam logic [2:0] LOW = 3'b000, STBY = 3'b001, SCAN = 3'b010,
                           IDLE = 3'b011, FLUSH = 3'b100, XFR = 3'b101;

    logic       clk = 1'b0;
    logic       reset, mission_en, link_ok;
    logic [2:0] state1, state2;
    logic [7:0] mem_used1, mem_used2;
    logic       goto_stby1, goto_stby2, start_scan1, start_scan2;
    logic       xfer1, xfer2, active, fault;
    logic [7:0] xfer_cnt, drop_cnt;
    logic [7:0] outv;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    typedef struct packed {
        logic       mis;
        logic       lnk;
        logic       a;
        logic [7:0] mem;
        logic [2:0] sa;
        logic [2:0] sb;
        logic [7:0] e;
    } row_t;

    scan_scheduler #(.WAKE_LVL(80), .START_LVL(90), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .mission_en(mission_en), .link_ok(link_ok),
        .state1(state1), .state2(state2), .mem_used1(mem_used1), .mem_used2(mem_used2),
        .goto_stby1(goto_stby1), .goto_stby2(goto_stby2),
        .start_scan1(start_scan1), .start_scan2(start_scan2),
        .xfer1(xfer1), .xfer2(xfer2), .active(active),
        .xfer_cnt(xfer_cnt), .drop_cnt(drop_cnt), .fault(fault)
    );

    always #5 clk = ~clk;

    assign outv = {goto_stby1, goto_stby2, start_scan1, start_scan2, xfer1, xfer2, active, fault};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive A/B-relative inputs onto the physical scanner ports; B's buffer is held empty.
    task automatic setab(input logic a, input logic [7:0] mem, input logic [2:0] sa, input logic [2:0] sb);
        if (a == 1'b0) begin
            mem_used1 = mem; state1 = sa; mem_used2 = 8'd0; state2 = sb;
        end else begin
            mem_used2 = mem; state2 = sa; mem_used1 = 8'd0; state1 = sb;
        end
    endtask

    function automatic row_t mk(input logic mis, input logic lnk, input logic a, input logic [7:0] mem,
                                input logic [2:0] sa, input logic [2:0] sb, input logic [7:0] e);
        row_t r;
        r.mis = mis; r.lnk = lnk; r.a = a; r.mem = mem; r.sa = sa; r.sb = sb; r.e = e;
        return r;
    endfunction

    task automatic apply_row(input row_t r);
        mission_en = r.mis;
        link_ok    = r.lnk;
        setab(r.a, r.mem, r.sa, r.sb);
        exp_q.push_back(r.e);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mission_en = 1'b0; link_ok = 1'b0;
        mem_used1 = 8'd0; mem_used2 = 8'd0; state1 = LOW; state2 = LOW;
        tick();
        reset = 1'b0;
    endtask

    task automatic handoff(input logic a);
        mission_en = 1'b1;
        link_ok    = 1'b1;
        setab(a, 8'd80, SCAN, LOW);  tick();
        setab(a, 8'd90, SCAN, STBY); tick();
        tick();
        setab(a, 8'd100, XFR, SCAN); tick();
        setab(a, 8'd100, LOW, SCAN); tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mission_en = 1'b1; link_ok = 1'b1;
        mem_used1 = 8'd100; mem_used2 = 8'd0; state1 = SCAN; state2 = LOW;
        tick(); tick();
        n_tests++;
        if (outv !== 8'd0) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", outv, 8'd0); end
        n_tests++;
        if ({xfer_cnt, drop_cnt} !== 16'd0) begin
            n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", xfer_cnt, drop_cnt);
        end
        mission_en = 1'b0;
        reset = 1'b0;
        tick(); tick();
        n_tests++;
        if (outv !== 8'd0) begin n_fail++; $display("FAIL reset_off_idle: got %b want %b", outv, 8'd0); end
    endtask

    task automatic test_normal();
        row_t rows[$];
        logic [7:0] e;
        do_reset();
        rows.push_back(mk(1, 1, 0, 8'd0,   SCAN, LOW,  8'b00000000));
        rows.push_back(mk(1, 1, 0, 8'd70,  SCAN, LOW,  8'b00000000));
        rows.push_back(mk(1, 1, 0, 8'd80,  SCAN, LOW,  8'b01000000));
        rows.push_back(mk(1, 1, 0, 8'd81,  SCAN, LOW,  8'b00000000));
        rows.push_back(mk(1, 1, 0, 8'd82,  SCAN, LOW,  8'b00000000));
        rows.push_back(mk(1, 1, 0, 8'd83,  SCAN, STBY, 8'b00000000));
        rows.push_back(mk(1, 1, 0, 8'd85,  SCAN, STBY, 8'b00000000));
        rows.push_back(mk(1, 1, 0, 8'd90,  SCAN, STBY, 8'b00010000));
        rows.push_back(mk(1, 1, 0, 8'd100, SCAN, SCAN, 8'b00001000));
        rows.push_back(mk(1, 0, 0, 8'd100, SCAN, SCAN, 8'b00000000));
        rows.push_back(mk(1, 1, 0, 8'd100, SCAN, SCAN, 8'b00001000));
        rows.push_back(mk(1, 0, 0, 8'd100, XFR,  SCAN, 8'b00001000));
        rows.push_back(mk(1, 0, 0, 8'd100, XFR,  SCAN, 8'b00001000));
        rows.push_back(mk(1, 1, 0, 8'd100, LOW,  SCAN, 8'b00000010));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            e = exp_q.pop_front();
            n_tests++;
            if (outv !== e) begin n_fail++; $display("FAIL normal[%0d]: got %b want %b", i, outv, e); end
        end
        n_tests++;
        if (xfer_cnt !== 8'd1 || drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL normal_counts: got %0d/%0d want 1/0", xfer_cnt, drop_cnt);
        end
    endtask

    task automatic test_drop();
        row_t rows[$];
        logic [7:0] e;
        do_reset();
        rows.push_back(mk(1, 0, 0, 8'd0,   SCAN,  LOW,  8'b00000000));
        rows.push_back(mk(1, 0, 0, 8'd80,  SCAN,  LOW,  8'b01000000));
        rows.push_back(mk(1, 0, 0, 8'd85,  SCAN,  STBY, 8'b00000000));
        rows.push_back(mk(1, 0, 0, 8'd90,  SCAN,  STBY, 8'b00010000));
        rows.push_back(mk(1, 0, 0, 8'd100, SCAN,  SCAN, 8'b00000000));
        rows.push_back(mk(1, 0, 0, 8'd100, IDLE,  SCAN, 8'b00000000));
        rows.push_back(mk(1, 0, 0, 8'd100, FLUSH, SCAN, 8'b00000000));
        rows.push_back(mk(1, 0, 0, 8'd100, LOW,   SCAN, 8'b00000010));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            e = exp_q.pop_front();
            n_tests++;
            if (outv !== e) begin n_fail++; $display("FAIL drop[%0d]: got %b want %b", i, outv, e); end
        end
        n_tests++;
        if (xfer_cnt !== 8'd0 || drop_cnt !== 8'd1) begin
            n_fail++; $display("FAIL drop_counts: got %0d/%0d want 0/1", xfer_cnt, drop_cnt);
        end
    endtask

    task automatic test_timeout();
        row_t rows[$];
        logic [7:0] e;
        do_reset();
        rows.push_back(mk(1, 0, 0, 8'd0,  SCAN, LOW, 8'b00000000));
        rows.push_back(mk(1, 0, 0, 8'd95, SCAN, LOW, 8'b01000000));
        for (int i = 0; i < 4; i++) rows.push_back(mk(1, 0, 0, 8'd95, SCAN, LOW, 8'b00000000));
        rows.push_back(mk(1, 0, 0, 8'd95, SCAN, LOW, 8'b01000001));
        for (int i = 0; i < 4; i++) rows.push_back(mk(1, 0, 0, 8'd95, SCAN, LOW, 8'b00000001));
        rows.push_back(mk(1, 0, 0, 8'd95, SCAN, LOW,  8'b01000001));
        rows.push_back(mk(1, 0, 0, 8'd95, SCAN, STBY, 8'b00000001));
        rows.push_back(mk(1, 0, 0, 8'd95, SCAN, STBY, 8'b00010001));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            e = exp_q.pop_front();
            n_tests++;
            if (outv !== e) begin n_fail++; $display("FAIL timeout[%0d]: got %b want %b", i, outv, e); end
        end
    endtask

    task automatic test_grant();
        logic       a, lk;
        logic [7:0] e, got;
        do_reset();
        mission_en = 1'b1;
        tick();
        for (int h = 0; h < 2; h++) begin
            a = h[0];
            link_ok = 1'b1;
            setab(a, 8'd80, SCAN, LOW);  tick();
            setab(a, 8'd90, SCAN, STBY); tick();
            tick();
            for (int k = 0; k < 6; k++) begin
                lk = k[0];
                link_ok = lk;
                setab(a, 8'd100, SCAN, SCAN);
                exp_q.push_back(a ? {6'd0, 1'b0, lk} : {6'd0, lk, 1'b0});
                tick();
                got = {6'd0, xfer1, xfer2};
                e = exp_q.pop_front();
                n_tests++;
                if (got !== e) begin n_fail++; $display("FAIL grant_fill h%0d k%0d: got %b want %b", h, k, got, e); end
            end
            for (int k = 0; k < 5; k++) begin
                link_ok = k[0];
                setab(a, 8'd100, XFR, SCAN);
                exp_q.push_back(a ? 8'b01 : 8'b10);
                tick();
                got = {6'd0, xfer1, xfer2};
                e = exp_q.pop_front();
                n_tests++;
                if (got !== e) begin n_fail++; $display("FAIL grant_xfer h%0d k%0d: got %b want %b", h, k, got, e); end
            end
            link_ok = 1'b1;
            setab(a, 8'd100, LOW, SCAN);
            exp_q.push_back({5'd0, 2'b00, ~a});
            tick();
            got = {5'd0, xfer1, xfer2, active};
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL grant_release h%0d: got %b want %b", h, got, e); end
        end
    endtask

    task automatic test_enable();
        row_t rows[$];
        logic [7:0] e;
        do_reset();
        mission_en = 1'b1;
        tick();
        handoff(1'b0);
        rows.push_back(mk(1, 0, 1, 8'd80,  SCAN, LOW,  8'b10000010));
        rows.push_back(mk(1, 0, 1, 8'd85,  SCAN, STBY, 8'b00000010));
        rows.push_back(mk(0, 0, 1, 8'd85,  SCAN, STBY, 8'b00000010));
        rows.push_back(mk(0, 0, 1, 8'd90,  SCAN, STBY, 8'b00100010));
        rows.push_back(mk(0, 1, 1, 8'd100, SCAN, SCAN, 8'b00000110));
        rows.push_back(mk(0, 0, 1, 8'd100, XFR,  SCAN, 8'b00000110));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            e = exp_q.pop_front();
            n_tests++;
            if (outv !== e) begin n_fail++; $display("FAIL enable[%0d]: got %b want %b", i, outv, e); end
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (outv !== 8'd0) begin n_fail++; $display("FAIL async_reset_outputs: got %b want %b", outv, 8'd0); end
        n_tests++;
        if (xfer_cnt !== 8'd0) begin n_fail++; $display("FAIL async_reset_cnt: got %0d want 0", xfer_cnt); end
        reset = 1'b0;
        rows.delete();
        rows.push_back(mk(0, 0, 0, 8'd0,  SCAN, LOW, 8'b00000000));
        rows.push_back(mk(1, 0, 0, 8'd0,  SCAN, LOW, 8'b00000000));
        rows.push_back(mk(0, 0, 0, 8'd85, SCAN, LOW, 8'b00000000));
        rows.push_back(mk(1, 0, 0, 8'd85, SCAN, LOW, 8'b00000000));
        rows.push_back(mk(1, 0, 0, 8'd85, SCAN, LOW, 8'b01000000));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            e = exp_q.pop_front();
            n_tests++;
            if (outv !== e) begin n_fail++; $display("FAIL restart[%0d]: got %b want %b", i, outv, e); end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] cnt_q[$];
        logic [7:0] e;
        do_reset();
        mission_en = 1'b1;
        tick();
        for (int i = 0; i < 260; i++) begin
            cnt_q.push_back((i + 1 > 255) ? 8'd255 : 8'(i + 1));
            handoff(i[0]);
            e = cnt_q.pop_front();
            n_tests++;
            if (xfer_cnt !== e) begin n_fail++; $display("FAIL sat_xfer_cnt[%0d]: got %0d want %0d", i, xfer_cnt, e); end
        end
        n_tests++;
        if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_drop_cnt: got %0d want 0", drop_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mission_en = 1'b0; link_ok = 1'b0;
        mem_used1 = 8'd0; mem_used2 = 8'd0; state1 = LOW; state2 = LOW;
        test_reset();
        test_normal();
        test_drop();
        test_timeout();
        test_grant();
        test_enable();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_scheduler.md
# scan_scheduler

Sequencing controller for the two-scanner subsystem (primary scanner 1, alternate scanner 2). It decides which scanner is active, wakes the other one ahead of time with standby/start-scan command pulses, and grants the single shared downlink (`xfer`) to at most one scanner. It counts completed downlinks and dropped (flushed) buffers. It sits between mission control and the two scanner instances, replacing the direct cross-wiring of their `goto_stby`/`start_scan` handshake outputs.

## Interface
- `WAKE_LVL`, default 80: active-scanner `mem_used` at or above which the other scanner is sent to standby.
- `START_LVL`, default 90: active-scanner `mem_used` at or above which the other scanner is told to start scanning.
- `TIMEOUT`, default 255: cycles allowed in WAIT_STBY before a retry; must be 1..255 (8-bit counter).
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs immediately.
- `mission_en` in 1: scheduling enable.
- `link_ok` in 1: downlink available.
- `state1`, `state2` in 3: scanner state codes (000 low_pwr, 001 stby, 010 scanning, 011 idle, 100 flushing, 101 xferring).
- `mem_used1`, `mem_used2` in 8: scanner buffer occupancy, 0..100.
- `goto_stby1`, `goto_stby2` out 1: one-cycle command pulse.
- `start_scan1`, `start_scan2` out 1: one-cycle command pulse.
- `xfer1`, `xfer2` out 1: downlink grant level; never both high.
- `active` out 1: 0 means scanner 1 is active, 1 means scanner 2 is active.
- `xfer_cnt` out 8: completed downlinks; saturates at 255.
- `drop_cnt` out 8: buffers flushed without downlink; saturates at 255.
- `fault` out 1: sticky; set by a standby timeout.

## Operation
- All outputs are registered.
- Reset values: FSM in OFF, `active` = 0, every pulse and grant output 0, both counters 0, `fault` 0, timeout counter 0.
- Notation: "A" means the active scanner's signals (selected by `active`); "B" means the other scanner's.
- FSM states:
  - **OFF**: no outputs asserted. If `mission_en` = 1, go to RUN.
  - **RUN**: if `mission_en` = 0, go to OFF. Otherwise, if `mem_usedA` >= `WAKE_LVL`, pulse `goto_stbyB`, clear the timer and go to WAIT_STBY.
  - **WAIT_STBY**: if `stateB` == stby, go to ARMED.
    - If the timer reaches `TIMEOUT`, set `fault`, re-pulse `goto_stbyB`, clear the timer and stay in WAIT_STBY.
    - Otherwise increment the timer.
  - **ARMED**: if `mem_usedA` >= `START_LVL`, pulse `start_scanB` and go to FILL.
  - **FILL**: drive `xferA` = registered `link_ok`.
    - `stateA` == xferring: go to XFER.
    - `stateA` == idle: go to DRAIN.
  - **XFER**: hold `xferA` = 1, regardless of `link_ok`. When `stateA` == low_pwr, increment `xfer_cnt`, toggle `active`, clear `xferA` and go to RUN.
  - **DRAIN**: `xferA` = 0. When `stateA` == low_pwr, increment `drop_cnt`, toggle `active` and go to RUN.
- `mission_en` is sampled only in OFF and RUN. A handoff already in progress always completes.
- `xferB` is always 0, so the grant is mutually exclusive by construction.
- Counters saturate at 255 and do not wrap.
- Unlisted `stateA`/`stateB` codes (110, 111) cause no transition.

## Timing
- Thresholds are compared combinationally against the current inputs. The resulting pulse appears on the rising edge after the threshold is met: 1-cycle latency, exactly 1 cycle wide.
- The FSM advances at most one state per cycle. Any command pulse, count increment or `active` toggle happens on the same edge as the transition that causes it.
- `xferA` follows `link_ok` with 1-cycle latency while in FILL, and stays latched high once XFER is entered.
- Simultaneous events in RUN (`mission_en` falling and `mem_usedA` >= `WAKE_LVL`): OFF wins; no pulse is issued.
- Both thresholds met on entry to WAIT_STBY: `start_scanB` is still issued only after B reaches stby, through ARMED on a later cycle.
- Reset asserted mid-handoff: all outputs drop to their reset values asynchronously, and the FSM restarts from OFF with `active` = 0.

## Test plan
- **Normal handoff with downlink.** Stimulus: reset, `mission_en` = 1, `link_ok` = 1, `mem_used1` ramps 0→100; B reports stby 3 cycles after `goto_stby2`; A goes xferring, then low_pwr.
  - Response: `goto_stby2` pulses once, on the cycle after `mem_used1` = 80.
  - `start_scan2` pulses once, on the cycle after `mem_used1` = 90.
  - `xfer1` = 1 through XFER; `xfer2` stays 0.
  - On A's low_pwr: `xfer_cnt` = 1 and `active` = 1.
- **Drop path.** Stimulus: same as above but `link_ok` = 0; A goes idle, then flushing, then low_pwr.
  - Response: `xfer1` stays 0; `drop_cnt` = 1, `xfer_cnt` = 0, `active` = 1.
- **Standby timeout.** Stimulus: `TIMEOUT` = 4; B never reports stby.
  - Response: `goto_stby2` re-pulses every 5 cycles; `fault` = 1 after the first retry and stays 1.
  - B then reports stby: transition to ARMED with `fault` still 1.
- **Grant exclusivity and latch.** Stimulus: toggle `link_ok` every cycle during FILL and XFER across two full handoffs.
  - Response: `xfer1` and `xfer2` are never both 1; the grant holds at 1 throughout XFER.
- **Enable and reset boundaries.** Stimulus: deassert `mission_en` in ARMED; then assert `reset` in XFER.
  - Response: the handoff continues to FILL despite `mission_en` = 0.
  - On `reset`: all outputs are 0 with no wait for a clock edge; `active` = 0; the FSM is in OFF.
- **Counter saturation.** Stimulus: run 260 handoffs.
  - Response: `xfer_cnt` holds at 255 and does not wrap.
